debounce_bank: RTL and testbench

- Multi-channel debouncer for TM1638 key-scan inputs and other raw push-button lines.
- Each channel has an input synchronizer and symmetric debounce: the output changes only after the new level has been stable for DEBOUNCE_CYCLES samples, on both press and release.
- Each channel generates one-cycle press/release pulses and an optional auto-repeat pulse while the key is held.
- Sits between the key-scan shift logic and the display/control FSMs.

---
 rtl/debounce_pkg.sv | 8 +
 rtl/debounce_channel.sv | 73 +++++++
 rtl/debounce_bank.sv | 39 +++
 tb/tb_debounce_bank.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants, edge type and width helper for the debounce bank
package debounce_pkg;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   typedef enum logic [1:0] {EDGE_NONE, EDGE_PRESS, EDGE_RELEASE} edge_e;
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronized, symmetrically debounced input with edge pulses and auto-repeat
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = 1000,
   parameter int REPEAT_PERIOD   = 250,
   parameter int REPEAT_EN       = 1
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Data,
   output logic o_State,
   output logic o_Press,
   output logic o_Release,
   output logic o_Repeat
);
   localparam int CW = clog2_min1(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic w_s, w_accept;
   edge_e w_edge;
   logic [CW-1:0] r_cnt;
   logic r_state, r_press, r_release;
   if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = i_Data;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge i_Clk)
         r_sync <= i_Rst ? '0 : SYNC_STAGES'({r_sync, i_Data});
      assign w_s = r_sync[SYNC_STAGES-1];
   end
   assign w_accept = (w_s != r_state) && (r_cnt == CNT_LAST);
   assign w_edge   = !w_accept ? EDGE_NONE : (w_s ? EDGE_PRESS : EDGE_RELEASE);
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_cnt     <= '0;
         r_state   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_cnt     <= (w_s == r_state || w_accept) ? '0 : r_cnt + 1'b1;
         r_state   <= w_accept ? w_s : r_state;
         r_press   <= w_edge == EDGE_PRESS;
         r_release <= w_edge == EDGE_RELEASE;
      end
   end
   // hold counter is r_hold cycles past the press cycle; a release cancels any pulse due in its cycle
   if (REPEAT_EN != 0) begin : g_rep
      localparam int HW = clog2_min1(REPEAT_DELAY + 1);
      localparam logic [HW-1:0] HOLD_TOP    = HW'(REPEAT_DELAY);
      localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);
      logic [HW-1:0] r_hold, w_hold_inc;
      logic r_rep, w_fire;
      assign w_hold_inc = r_hold + 1'b1;
      assign w_fire     = r_state && (w_edge != EDGE_RELEASE) && (w_hold_inc == HOLD_TOP);
      always_ff @(posedge i_Clk) begin
         if (i_Rst) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
         end else begin
            r_hold <= (!r_state || w_edge == EDGE_RELEASE) ? '0 : (w_fire ? HOLD_RELOAD : w_hold_inc);
            r_rep  <= w_fire;
         end
      end
      assign o_Repeat = r_rep;
   end else begin : g_norep
      assign o_Repeat = 1'b0;
   end
   assign o_State   = r_state;
   assign o_Press   = r_press;
   assign o_Release = r_release;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: array of independent debounce channels with an any-key-down flag
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS        = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = 1000,
   parameter int REPEAT_PERIOD   = 250,
   parameter int REPEAT_EN       = 1
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic [CHANNELS-1:0] i_Data,
   output logic [CHANNELS-1:0] o_State,
   output logic [CHANNELS-1:0] o_Press,
   output logic [CHANNELS-1:0] o_Release,
   output logic [CHANNELS-1:0] o_Repeat,
   output logic                o_Any
);
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .REPEAT_EN      (REPEAT_EN)
      ) u_ch (
         .i_Clk    (i_Clk),
         .i_Rst    (i_Rst),
         .i_Data   (i_Data[c]),
         .o_State  (o_State[c]),
         .o_Press  (o_Press[c]),
         .o_Release(o_Release[c]),
         .o_Repeat (o_Repeat[c])
      );
   end
   assign o_Any = |o_State;
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: table, directed and randomized checks of debounce_bank against a history-based model
module tb_debounce_bank;
   localparam int CH = 8, SYNC = 2, D = 4, DELAY = 20, PERIOD = 5;
   logic i_Clk = 1'b0, i_Rst = 1'b1;
   logic [CH-1:0] i_Data = '0;
   logic [CH-1:0] o_State, o_Press, o_Release, o_Repeat;
   logic o_Any;
   int n_checks = 0, n_err = 0, cyc = 0;
   bit m_sync[CH][SYNC];
   bit m_hist[CH][D];
   int m_nsamp[CH];
   bit m_state[CH];
   int m_press_t[CH];
   logic [CH-1:0] e_state, e_press, e_rel, e_rep;
   typedef struct packed {logic [7:0] d, st, pr, rl;} vec_t;
   vec_t tbl[$];

   debounce_bank #(
      .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .REPEAT_EN(1)
   ) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Data(i_Data), .o_State(o_State),
      .o_Press(o_Press), .o_Release(o_Release), .o_Repeat(o_Repeat), .o_Any(o_Any)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // new level accepted once the last D post-synchronizer samples all differ from it;
   // repeats fall at DELAY + k*PERIOD cycles after the press while still held
   task automatic model(input logic rst, input logic [CH-1:0] d);
      cyc++;
      for (int c = 0; c < CH; c++) begin
         bit s, acc;
         if (rst) begin
            for (int k = 0; k < SYNC; k++) m_sync[c][k] = 0;
            for (int k = 0; k < D; k++) m_hist[c][k] = 0;
            m_nsamp[c] = 0;
            m_state[c] = 0;
            e_press[c] = 0;
            e_rel[c] = 0;
            e_rep[c] = 0;
         end else begin
            s = m_sync[c][SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
            m_sync[c][0] = d[c];
            for (int k = D - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = s;
            if (m_nsamp[c] < D) m_nsamp[c]++;
            acc = (m_nsamp[c] == D);
            for (int k = 0; k < D; k++) if (m_hist[c][k] == m_state[c]) acc = 0;
            e_press[c] = acc && s;
            e_rel[c] = acc && !s;
            if (acc) begin
               m_state[c] = s;
               if (s) m_press_t[c] = cyc;
            end
            e_rep[c] = m_state[c] && !e_press[c] && (cyc - m_press_t[c] >= DELAY)
                       && ((cyc - m_press_t[c] - DELAY) % PERIOD == 0);
         end
         e_state[c] = m_state[c];
      end
   endtask

   task automatic step(input logic rst, input logic [CH-1:0] d);
      i_Rst = rst;
      i_Data = d;
      model(rst, d);
      @(posedge i_Clk);
      #1;
      chk("state", o_State, e_state);
      chk("press", o_Press, e_press);
      chk("release", o_Release, e_rel);
      chk("repeat", o_Repeat, e_rep);
      chk("any", o_Any, |e_state);
   endtask

   task automatic add(input logic [7:0] d, st, pr, rl);
      tbl.push_back({d, st, pr, rl});
   endtask

   initial begin
      int p, rel_cnt, rel_at, low_start;
      int reps[$];
      logic [CH-1:0] rd;
      repeat (5) add(8'hFF, 8'h00, 8'h00, 8'h00);
      add(8'hFF, 8'hFF, 8'hFF, 8'h00);
      add(8'hFF, 8'hFF, 8'h00, 8'h00);
      repeat (5) add(8'h00, 8'hFF, 8'h00, 8'h00);
      add(8'h00, 8'h00, 8'h00, 8'hFF);
      add(8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) add(8'h02, 8'h00, 8'h00, 8'h00);
      add(8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) add(8'h02, 8'h00, 8'h00, 8'h00);
      repeat (6) add(8'h00, 8'h00, 8'h00, 8'h00);

      repeat (3) step(1'b1, '0);
      foreach (tbl[i]) begin
         step(1'b0, tbl[i].d);
         chk("tbl_state", o_State, tbl[i].st);
         chk("tbl_press", o_Press, tbl[i].pr);
         chk("tbl_release", o_Release, tbl[i].rl);
      end

      repeat (8) step(1'b0, 8'h01);
      step(1'b0, 8'h00); step(1'b0, 8'h00); step(1'b0, 8'h01); step(1'b0, 8'h01);
      low_start = cyc + 1;
      rel_cnt = 0;
      rel_at = -1;
      repeat (10) begin
         step(1'b0, 8'h00);
         if (o_Release[0]) begin rel_cnt++; rel_at = cyc; end
      end
      chk("bounce_release_count", rel_cnt, 1);
      chk("bounce_release_latency", rel_at - low_start, 5);

      p = -1;
      for (int i = 0; i < 20 && p < 0; i++) begin
         step(1'b0, 8'h04);
         if (o_Press[2]) p = cyc;
      end
      chk("press2_seen", p >= 0, 1);
      if (p < 0) p = cyc;
      rel_at = -1;
      while (cyc < p + 60) begin
         step(1'b0, (cyc < p + 29) ? 8'h04 : 8'h00);
         if (o_Repeat[2]) reps.push_back(cyc - p);
         if (o_Release[2]) rel_at = cyc - p;
      end
      chk("repeat_count", reps.size(), 3);
      if (reps.size() >= 3) begin
         chk("repeat_first", reps[0], 20);
         chk("repeat_second", reps[1], 25);
         chk("repeat_third", reps[2], 30);
      end
      chk("release2_offset", rel_at, 35);

      repeat (8) step(1'b0, 8'h10);
      repeat (4) step(1'b0, 8'h18);
      step(1'b1, 8'h18);
      chk("rst_state", o_State, 0);
      chk("rst_any", o_Any, 0);
      repeat (5) step(1'b0, 8'h18);
      chk("rst_exit_state", o_State, 0);
      step(1'b0, 8'h18);
      chk("rst_repress", o_Press, 8'h18);
      chk("rst_restate", o_State, 8'h18);

      rd = '0;
      repeat (3000) begin
         for (int c = 0; c < CH; c++) if ($urandom_range(0, 3 + 8 * c) == 0) rd[c] = ~rd[c];
         step($urandom_range(0, 499) == 0, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
